// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: jump redirect, multi-cycle front-end flush, N-source stall.
// Optional interrupt entry is built only when CTRL_IRQ_EN is defined.
module pipe_hazard_ctrl #(
    parameter int STAGES       = 4,
    parameter int ADDR_W       = 32,
    parameter int NUM_HOLD     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_en_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic [NUM_HOLD-1:0] hold_req_i,
`ifdef CTRL_IRQ_EN
    input  logic                irq_i,
    input  logic [ADDR_W-1:0]   irq_addr_i,
    output logic                irq_ack_o,
`endif
    output logic                jump_en_o,
    output logic [ADDR_W-1:0]   jump_addr_o,
    output logic [STAGES-1:0]   stall_o,
    output logic [STAGES-1:0]   flush_o,
    output logic                busy_o
);

    // state | meaning
    // IDLE  | no redirect in progress
    // FLUSH | front end held in flush for the remaining cnt cycles
    // PEND  | jump captured under hold, redirect issued when hold drops
    typedef enum logic [1:0] {IDLE, FLUSH, PEND} state_t;

    localparam bit          MULTI    = (FLUSH_CYCLES > 1);
    localparam logic [3:0]  CNT_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [STAGES-1:0] FRONT = {1'b0, {(STAGES-1){1'b1}}};

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   pend_addr;
    logic                irq_flush;
    logic                hold;
    logic                irq_take;

    assign hold = |hold_req_i;

`ifdef CTRL_IRQ_EN
    assign irq_take = irq_i & ~hold & ~jump_en_i & (state == IDLE);
`else
    assign irq_take = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_addr <= '0;
            irq_flush <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_en_i && hold) begin
                        pend_addr <= jump_addr_i;
                        state     <= PEND;
                    end else if ((jump_en_i || irq_take) && MULTI) begin
                        cnt       <= CNT_LOAD;
                        irq_flush <= irq_take;
                        state     <= FLUSH;
                    end
                end
                PEND: begin
                    if (jump_en_i)
                        pend_addr <= jump_addr_i;
                    if (!hold) begin
                        irq_flush <= 1'b0;
                        if (MULTI) begin
                            cnt   <= CNT_LOAD;
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (hold) begin
                        // A jump under hold is deferred rather than dropped.
                        if (jump_en_i) begin
                            pend_addr <= jump_addr_i;
                            cnt       <= '0;
                            irq_flush <= 1'b0;
                            state     <= PEND;
                        end
                    end else if (jump_en_i) begin
                        cnt       <= CNT_LOAD;
                        irq_flush <= 1'b0;
                    end else if (cnt <= 4'd1) begin
                        cnt       <= '0;
                        irq_flush <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        stall_o     = '0;
        flush_o     = '0;
        busy_o      = 1'b0;
`ifdef CTRL_IRQ_EN
        irq_ack_o   = 1'b0;
`endif
        if (!rst) begin
            busy_o = (state != IDLE);
            if (hold) begin
                stall_o = '1;
            end else begin
                case (state)
                    IDLE: begin
                        if (jump_en_i) begin
                            jump_en_o   = 1'b1;
                            jump_addr_o = jump_addr_i;
                            flush_o     = FRONT;
                        end
`ifdef CTRL_IRQ_EN
                        else if (irq_take) begin
                            irq_ack_o   = 1'b1;
                            jump_en_o   = 1'b1;
                            jump_addr_o = irq_addr_i;
                            flush_o     = '1;
                        end
`endif
                    end
                    PEND: begin
                        jump_en_o   = 1'b1;
                        jump_addr_o = jump_en_i ? jump_addr_i : pend_addr;
                        flush_o     = FRONT;
                    end
                    FLUSH: begin
                        flush_o = FRONT;
                        if (jump_en_i) begin
                            jump_en_o   = 1'b1;
                            jump_addr_o = jump_addr_i;
                        end else begin
                            flush_o[STAGES-1] = irq_flush;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl at default parameters.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_req_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [3:0]  stall_o;
    logic [3:0]  flush_o;
    logic        busy_o;
`ifdef CTRL_IRQ_EN
    logic        irq_i;
    logic [31:0] irq_addr_i;
    logic        irq_ack_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .hold_req_i  (hold_req_i),
`ifdef CTRL_IRQ_EN
        .irq_i       (irq_i),
        .irq_addr_i  (irq_addr_i),
        .irq_ack_o   (irq_ack_o),
`endif
        .jump_en_o   (jump_en_o),
        .jump_addr_o (jump_addr_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [2:0]  hold;
        logic        jump;
        logic [31:0] addr;
        logic        e_je;
        logic [31:0] e_addr;
        logic [3:0]  e_stall;
        logic [3:0]  e_flush;
        logic        e_busy;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic [2:0] h, logic j, logic [31:0] a, logic eje,
                                logic [31:0] ea, logic [3:0] es, logic [3:0] ef, logic eb);
        vec_t v;
        v.hold = h; v.jump = j; v.addr = a;
        v.e_je = eje; v.e_addr = ea; v.e_stall = es; v.e_flush = ef; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic eje, input logic [31:0] ea,
                         input logic [3:0] es, input logic [3:0] ef, input logic eb);
        n_vec++;
        if (jump_en_o !== eje || jump_addr_o !== ea || stall_o !== es ||
            flush_o !== ef || busy_o !== eb) begin
            n_err++;
            $display("FAIL %s: got je=%b addr=%h stall=%b flush=%b busy=%b, want je=%b addr=%h stall=%b flush=%b busy=%b",
                     name, jump_en_o, jump_addr_o, stall_o, flush_o, busy_o, eje, ea, es, ef, eb);
        end
    endtask

    task automatic drive(input logic [2:0] h, input logic j, input logic [31:0] a);
        @(negedge clk);
        hold_req_i  = h;
        jump_en_i   = j;
        jump_addr_i = a;
        #1;
    endtask

    initial begin
        vecs[0]  = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(3'b000, 1, 32'h100, 1, 32'h100, 4'b0000, 4'b0111, 0);
        vecs[2]  = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0111, 1);
        vecs[3]  = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[4]  = mk(3'b010, 1, 32'h200, 0, 32'h000, 4'b1111, 4'b0000, 0);
        vecs[5]  = mk(3'b010, 0, 32'h000, 0, 32'h000, 4'b1111, 4'b0000, 1);
        vecs[6]  = mk(3'b010, 0, 32'h000, 0, 32'h000, 4'b1111, 4'b0000, 1);
        vecs[7]  = mk(3'b000, 0, 32'h000, 1, 32'h200, 4'b0000, 4'b0111, 1);
        vecs[8]  = mk(3'b000, 1, 32'h300, 1, 32'h300, 4'b0000, 4'b0111, 1);
        vecs[9]  = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0111, 1);
        vecs[10] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[11] = mk(3'b000, 1, 32'h180, 1, 32'h180, 4'b0000, 4'b0111, 0);
        vecs[12] = mk(3'b001, 0, 32'h000, 0, 32'h000, 4'b1111, 4'b0000, 1);
        vecs[13] = mk(3'b100, 0, 32'h000, 0, 32'h000, 4'b1111, 4'b0000, 1);
        vecs[14] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0111, 1);
        vecs[15] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[16] = mk(3'b001, 1, 32'h240, 0, 32'h000, 4'b1111, 4'b0000, 0);
        vecs[17] = mk(3'b000, 1, 32'h280, 1, 32'h280, 4'b0000, 4'b0111, 1);
        vecs[18] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0111, 1);
        vecs[19] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[20] = mk(3'b010, 1, 32'h2A0, 0, 32'h000, 4'b1111, 4'b0000, 0);
        vecs[21] = mk(3'b110, 1, 32'h2C0, 0, 32'h000, 4'b1111, 4'b0000, 1);
        vecs[22] = mk(3'b000, 0, 32'h000, 1, 32'h2C0, 4'b0000, 4'b0111, 1);
        vecs[23] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0111, 1);
        vecs[24] = mk(3'b000, 0, 32'h000, 0, 32'h000, 4'b0000, 4'b0000, 0);
        vecs[25] = mk(3'b011, 0, 32'h000, 0, 32'h000, 4'b1111, 4'b0000, 0);

        rst = 1'b1;
        hold_req_i = '0; jump_en_i = 1'b1; jump_addr_i = 32'h123;
`ifdef CTRL_IRQ_EN
        irq_i = 1'b0; irq_addr_i = 32'h600;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_gate", 0, 32'h0, 4'b0000, 4'b0000, 0);
        drive(3'b000, 0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].hold, vecs[i].jump, vecs[i].addr);
            check($sformatf("vec%0d", i), vecs[i].e_je, vecs[i].e_addr,
                  vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_busy);
        end

        // Reset while a deferred redirect to 0x400 is pending.
        drive(3'b000, 0, 32'h0);
        drive(3'b010, 1, 32'h400);
        drive(3'b010, 0, 32'h0);
        check("pend_0x400", 0, 32'h0, 4'b1111, 4'b0000, 1);
        #2 rst = 1'b1;
        #1 check("rst_in_pend", 0, 32'h0, 4'b0000, 4'b0000, 0);
        drive(3'b000, 0, 32'h0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("after_rst%0d", i), 0, 32'h0, 4'b0000, 4'b0000, 0);
            drive(3'b000, 0, 32'h0);
        end

`ifdef CTRL_IRQ_EN
        irq_i = 1'b1;
        drive(3'b000, 1, 32'h500);
        check("irq_jump_first", 1, 32'h500, 4'b0000, 4'b0111, 0);
        n_vec++; if (irq_ack_o !== 1'b0) begin n_err++; $display("FAIL irq_ack_early: got %b want 0", irq_ack_o); end
        drive(3'b000, 0, 32'h0);
        check("irq_wait_flush", 0, 32'h0, 4'b0000, 4'b0111, 1);
        drive(3'b000, 0, 32'h0);
        check("irq_taken", 1, 32'h600, 4'b0000, 4'b1111, 0);
        n_vec++; if (irq_ack_o !== 1'b1) begin n_err++; $display("FAIL irq_ack: got %b want 1", irq_ack_o); end
        irq_i = 1'b0;
        drive(3'b000, 0, 32'h0);
        check("irq_flush2", 0, 32'h0, 4'b0000, 4'b1111, 1);
        n_vec++; if (irq_ack_o !== 1'b0) begin n_err++; $display("FAIL irq_ack_pulse: got %b want 0", irq_ack_o); end
        drive(3'b000, 0, 32'h0);
        check("irq_done", 0, 32'h0, 4'b0000, 4'b0000, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
